// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

  localparam logic [1:0] WLEN5 = 2'd0;
  localparam logic [1:0] WLEN6 = 2'd1;
  localparam logic [1:0] WLEN7 = 2'd2;
  localparam logic [1:0] WLEN8 = 2'd3;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY  = 3'd3,
`endif
    RX_STOP    = 3'd4,
    RX_BRKWAIT = 3'd5
  } rx_state_t;

  // Index of the final data bit for a given word-length code (5..8 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wl);
    return {1'b0, wl} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with a programmable reset level.
// Shared by the receive data path and the transmit CTS path.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled, 5-8 data bits, one-entry holding register.
// Define UART_RX_PARITY_EN to build the parity state, pen/eps handling and rx_pe.
module uart_rx
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       baudClk,
  input  logic       rxd,
  input  logic [1:0] wlen,
  input  logic       pen,
  input  logic       eps,
  input  logic       rx_ready,
  input  logic       oe_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_fe,
  output logic       rx_pe,
  output logic       rx_be,
  output logic       rx_oe,
  output logic       rx_busy
);

  rx_state_t  state, state_nxt;
  logic       rxd_s;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [1:0] wlen_l;
  logic       mid_pt, bit_pt, deliver, overrun;
  logic       fe_new, pe_new, be_new;

  uart_sync2 u_sync (
    .clk    (CLK),
    .rst_n  (RSTn),
    .rst_val(1'b1),
    .d      (rxd),
    .q      (rxd_s)
  );

  assign mid_pt  = (tick_cnt == MID_TICK);
  assign bit_pt  = (tick_cnt == LAST_TICK);
  assign deliver = baudClk && (state == RX_STOP) && bit_pt;
  assign overrun = deliver && rx_valid && !rx_ready;
  assign rx_busy = (state != RX_IDLE);
  assign fe_new  = ~rxd_s;

`ifdef UART_RX_PARITY_EN
  logic pen_l, eps_l, par_bit;
  assign pe_new = pen_l & (^shreg ^ par_bit ^ ~eps_l);
  assign be_new = fe_new & (shreg == 8'h00) & (~pen_l | ~par_bit);
`else
  logic unused_fmt;
  assign unused_fmt = pen ^ eps;
  assign pe_new     = 1'b0;
  assign be_new     = fe_new & (shreg == 8'h00);
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (baudClk) begin
      case (state)
        RX_IDLE:    if (!rxd_s) state_nxt = RX_START;
        RX_START:   if (mid_pt) state_nxt = rxd_s ? RX_IDLE : RX_DATA;
        RX_DATA:
          if (bit_pt && (bit_cnt == last_bit_idx(wlen_l))) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = pen_l ? RX_PARITY : RX_STOP;
`else
            state_nxt = RX_STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        RX_PARITY:  if (bit_pt) state_nxt = RX_STOP;
`endif
        RX_STOP:    if (bit_pt) state_nxt = rxd_s ? RX_IDLE : RX_BRKWAIT;
        RX_BRKWAIT: if (rxd_s)  state_nxt = RX_IDLE;
        default:    state_nxt = RX_IDLE;
      endcase
    end
  end

  // Bit timing and shift register; format is frozen at the start midpoint.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      wlen_l   <= '0;
`ifdef UART_RX_PARITY_EN
      pen_l    <= 1'b0;
      eps_l    <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else if (baudClk) begin
      case (state)
        RX_IDLE, RX_BRKWAIT: tick_cnt <= '0;
        RX_START: begin
          if (mid_pt) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            wlen_l   <= wlen;
`ifdef UART_RX_PARITY_EN
            pen_l    <= pen;
            eps_l    <= eps;
            par_bit  <= 1'b0;
`endif
          end else begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        default: begin
          tick_cnt <= bit_pt ? 4'd0 : tick_cnt + 4'd1;
          if (bit_pt && (state == RX_DATA)) begin
            shreg[bit_cnt] <= rxd_s;
            bit_cnt        <= bit_cnt + 3'd1;
          end
`ifdef UART_RX_PARITY_EN
          if (bit_pt && (state == RX_PARITY)) par_bit <= rxd_s;
`endif
        end
      endcase
    end
  end

  // Holding register: a same-cycle pop frees the slot for the incoming word.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_fe    <= 1'b0;
      rx_be    <= 1'b0;
      rx_oe    <= 1'b0;
    end else begin
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_fe    <= fe_new;
        rx_be    <= be_new;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (overrun)     rx_oe <= 1'b1;
      else if (oe_clr) rx_oe <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                    rx_pe <= 1'b0;
    else if (deliver && (!rx_valid || rx_ready)) rx_pe <= pe_new;
  end
`else
  assign rx_pe = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine for the pipelined core's serial port. It consumes the single-cycle 16x oversampling enable `baudClk` produced by `baud_rate_generator`, samples the serial input at mid-bit, and assembles 5–8-bit frames with optional parity. Each word lands in a one-entry holding register with error status; the bus side drains it through a valid/ready handshake.

## Interface
- No parameters; all frame format is run-time programmable.
- CLK  input  1  UARTCLK domain; same clock as `baud_rate_generator`.
- RSTn  input  1  asynchronous, active-low reset.
- baudClk  input  1  one-CLK-wide enable pulse at 16x baud rate.
- rxd  input  1  asynchronous serial line; idle high.
- wlen  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits. Sampled at start-bit validation.
- pen  input  1  parity enable.
- eps  input  1  even parity select (1=even, 0=odd).
- rx_ready  input  1  consumer accepts the holding word this cycle.
- oe_clr  input  1  clears sticky overrun flag.
- rx_data  output  8  received word, LSB-aligned; unused upper bits are 0.
- rx_valid  output  1  holding register full.
- rx_fe  output  1  framing error for the held word.
- rx_pe  output  1  parity error for the held word.
- rx_be  output  1  break condition for the held word.
- rx_oe  output  1  sticky overrun.
- rx_busy  output  1  frame in progress (state != IDLE).

## Operation
- rxd passes through a 2-flop synchronizer to give rxd_s. Reset value of the synchronizer is 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT. All state and counter updates are gated by baudClk, except the handshake.
- IDLE: on a baudClk tick with rxd_s=0, clear the tick counter and go to START.
- START: on tick count 7 (the 8th tick, mid-bit), resample rxd_s.
  - If rxd_s=0: latch the frame format and go to DATA.
  - If rxd_s=1: treat it as a glitch and return to IDLE with no output.
- Sampling rule: after the start midpoint, one sample is taken every 16 ticks (counter wraps 15→0 at the sample point).
- DATA: shift rxd_s in LSB first. After wlen+5 bits, go to PARITY if pen=1, otherwise go to STOP.
- PARITY: compare the sampled bit with the computed parity. For even parity, the XOR of data and parity bit must be 0; for odd, it must be 1. A mismatch sets pe.
- STOP: sample one stop bit; 0 sets fe.
  - be = fe & (all data bits 0) & (parity bit 0 or pen=0).
  - Deliver the word, then go to IDLE. If the stop sample was 0, go to BRKWAIT instead.
- BRKWAIT: stay until rxd_s=1, then go to IDLE. This gives one word per break, regardless of break length.
- Delivery with the holding register empty: load rx_data, rx_fe, rx_pe and rx_be, and set rx_valid.
- Delivery with the holding register full: discard the new word and set rx_oe. The held word and its status are untouched.
- Handshake: rx_valid & rx_ready clears rx_valid on the next edge. Delivery and pop in the same cycle load the new word with no overrun.
- oe_clr clears rx_oe. If oe_clr coincides with a new overrun, the overrun wins and rx_oe stays 1.
- Frame format inputs changing mid-frame do not affect the current frame.

## Timing
- Reset values: all outputs are 0, the FSM is in IDLE, and the counters are 0.
- Reset mid-frame aborts the frame immediately, with no delivery.
- rxd to rxd_s latency: 2 CLK.
- rx_valid rises 1 CLK after the baudClk edge that samples the stop bit.
- Worst-case frame: 1+8+1+1 bits = 176 ticks.
- Minimum baudClk spacing is 1 CLK (continuous enable). The block must work at any spacing.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state, pen/eps logic and rx_pe are present.
- UART_RX_PARITY_EN undefined:
  - pen and eps are ignored.
  - The PARITY state is removed.
  - rx_pe is tied to 0.
  - be ignores the parity bit.

## Structure
- uart_pkg:
  - rx_state_t enum.
  - wlen encoding constants (WLEN5..WLEN8).
  - OVERSAMPLE=16 and MID_TICK=7.
- Sub-module uart_sync2: 2-flop synchronizer with a reset value input. It is reused by the future uart_tx CTS path.

## Test plan
- 8N1 0xA5, baudClk every 2 CLK → rx_data=0xA5, rx_valid=1, fe=pe=be=0; rx_ready pop → rx_valid=0 next cycle.
- rxd low for 5 ticks then high → stays IDLE; no rx_valid, rx_busy back to 0.
- wlen=1, pen=1, eps=1, 0x2C sent with bad parity bit → rx_data=0x2C, rx_pe=1, rx_fe=0.
- rxd held low 20 bit times, 8N1 → exactly one word: rx_data=0x00, rx_fe=1, rx_be=1; next frame 0x55 is received normally after rxd returns high.
- Frames 0x11 then 0x22 with no rx_ready → rx_data=0x11, rx_oe=1; oe_clr → rx_oe=0; pop then 0x33 → rx_data=0x33.
- RSTn low during data bit 3 of 0xF0 → all outputs 0, FSM IDLE; after release, 0x0F is received correctly.
